// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter.
    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Width needed to hold a fill count of 0..depth inclusive.
    function automatic int unsigned fifo_count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to address depth storage words (at least one bit).
    function automatic int unsigned fifo_ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH incrementing pointer; wraps from DEPTH-1 back to 0 for any DEPTH.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = fifo_ptr_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Advance on enable, wrapping explicitly at the last storage index.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_fwft_count.sv
// Single-clock FIFO with arbitrary depth, selectable standard/FWFT read path,
// live fill count, threshold flags and sticky overflow/underflow flags.
module fifo_fwft_count
    import fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned FWFT  = FIFO_MODE_STD,
    localparam int unsigned CW    = fifo_count_width(DEPTH)
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Wr_DV,
    input  logic [WIDTH-1:0] i_Wr_Data,
    input  logic [CW-1:0]    i_AF_Level,
    output logic             o_AF_Flag,
    output logic             o_Full,
    input  logic             i_Rd_En,
    output logic             o_Rd_DV,
    output logic [WIDTH-1:0] o_Rd_Data,
    input  logic [CW-1:0]    i_AE_Level,
    output logic             o_AE_Flag,
    output logic             o_Empty,
    output logic [CW-1:0]    o_Count,
    input  logic             i_Clr_Err,
    output logic             o_Overflow,
    output logic             o_Underflow
);

    localparam int unsigned PW = fifo_ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_accept;
    logic             wr_accept;

    // A read needs stored data; a write into a full FIFO is legal only when a read frees a slot.
    assign rd_accept = i_Rd_En && !o_Empty;
    assign wr_accept = i_Wr_DV && (!o_Full || rd_accept);

    fifo_wrap_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk_i (i_Clk),
        .rst_i (i_Rst),
        .en_i  (wr_accept),
        .ptr_o (wr_ptr)
    );

    fifo_wrap_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk_i (i_Clk),
        .rst_i (i_Rst),
        .en_i  (rd_accept),
        .ptr_o (rd_ptr)
    );

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge i_Clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr] <= i_Wr_Data;
        end
    end

    // Next count and sticky errors; a new error wins over a coincident clear.
    always_comb begin
        count_d = count_q;
        if (wr_accept && !rd_accept) begin
            count_d = count_q + CW'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - CW'(1);
        end
        overflow_d  = (overflow_q && !i_Clr_Err) || (i_Wr_DV && !wr_accept);
        underflow_d = (underflow_q && !i_Clr_Err) || (i_Rd_En && o_Empty);
    end

    // Count and error flag registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_Count     = count_q;
    assign o_Empty     = (count_q == '0);
    assign o_Full      = (count_q == CW'(DEPTH));
    assign o_AF_Flag   = (count_q >= i_AF_Level);
    assign o_AE_Flag   = (count_q <= i_AE_Level);
    assign o_Overflow  = overflow_q;
    assign o_Underflow = underflow_q;

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented combinationally whenever data is held.
        assign o_Rd_Data = mem_q[rd_ptr];
        assign o_Rd_DV   = !o_Empty;
    end else begin : g_std
        logic             rd_dv_q;
        logic [WIDTH-1:0] rd_data_q;

        // Registered read: one-cycle valid pulse, data holds until the next read.
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                rd_dv_q   <= 1'b0;
                rd_data_q <= '0;
            end else begin
                rd_dv_q <= rd_accept;
                if (rd_accept) begin
                    rd_data_q <= mem_q[rd_ptr];
                end
            end
        end

        assign o_Rd_Data = rd_data_q;
        assign o_Rd_DV   = rd_dv_q;
    end

endmodule

// File: tb/tb_fifo_fwft_count.sv
// Drives three FIFO variants (std depth 4, std depth 5, FWFT depth 4) with shared stimulus
// and compares every output each cycle against an ordered-list reference model.
module tb_fifo_fwft_count;

    logic       clk;
    logic       rst;
    logic       wr_dv;
    logic [7:0] wr_data;
    logic [2:0] af_level;
    logic [2:0] ae_level;
    logic       rd_en;
    logic       clr_err;

    logic       af_flag [3];
    logic       full    [3];
    logic       rd_dv   [3];
    logic [7:0] rd_data [3];
    logic       ae_flag [3];
    logic       empty   [3];
    logic [2:0] count   [3];
    logic       ovf     [3];
    logic       unf     [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each FIFO is an ordered list, element 0 is the oldest word.
    int         m_depth [3] = '{4, 5, 4};
    int         m_fwft  [3] = '{0, 0, 1};
    logic [7:0] m_buf   [3][8];
    int         m_cnt   [3];
    logic       m_ovf   [3];
    logic       m_unf   [3];
    logic       m_dv    [3];
    logic [7:0] m_data  [3];

    fifo_fwft_count #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_std4 (
        .i_Clk(clk), .i_Rst(rst), .i_Wr_DV(wr_dv), .i_Wr_Data(wr_data),
        .i_AF_Level(af_level), .o_AF_Flag(af_flag[0]), .o_Full(full[0]),
        .i_Rd_En(rd_en), .o_Rd_DV(rd_dv[0]), .o_Rd_Data(rd_data[0]),
        .i_AE_Level(ae_level), .o_AE_Flag(ae_flag[0]), .o_Empty(empty[0]),
        .o_Count(count[0]), .i_Clr_Err(clr_err), .o_Overflow(ovf[0]),
        .o_Underflow(unf[0])
    );

    fifo_fwft_count #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_std5 (
        .i_Clk(clk), .i_Rst(rst), .i_Wr_DV(wr_dv), .i_Wr_Data(wr_data),
        .i_AF_Level(af_level), .o_AF_Flag(af_flag[1]), .o_Full(full[1]),
        .i_Rd_En(rd_en), .o_Rd_DV(rd_dv[1]), .o_Rd_Data(rd_data[1]),
        .i_AE_Level(ae_level), .o_AE_Flag(ae_flag[1]), .o_Empty(empty[1]),
        .o_Count(count[1]), .i_Clr_Err(clr_err), .o_Overflow(ovf[1]),
        .o_Underflow(unf[1])
    );

    fifo_fwft_count #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_fwft4 (
        .i_Clk(clk), .i_Rst(rst), .i_Wr_DV(wr_dv), .i_Wr_Data(wr_data),
        .i_AF_Level(af_level), .o_AF_Flag(af_flag[2]), .o_Full(full[2]),
        .i_Rd_En(rd_en), .o_Rd_DV(rd_dv[2]), .o_Rd_Data(rd_data[2]),
        .i_AE_Level(ae_level), .o_AE_Flag(ae_flag[2]), .o_Empty(empty[2]),
        .o_Count(count[2]), .i_Clr_Err(clr_err), .o_Overflow(ovf[2]),
        .o_Underflow(unf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_ovf[i]  = 1'b0;
            m_unf[i]  = 1'b0;
            m_dv[i]   = 1'b0;
            m_data[i] = 8'h00;
        end
    endtask

    // Apply one clock edge worth of the current inputs to the model.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit rd_ok;
            bit wr_ok;
            rd_ok = rd_en && (m_cnt[i] > 0);
            wr_ok = wr_dv && ((m_cnt[i] < m_depth[i]) || rd_ok);
            m_ovf[i] = (m_ovf[i] && !clr_err) || (wr_dv && !wr_ok);
            m_unf[i] = (m_unf[i] && !clr_err) || (rd_en && (m_cnt[i] == 0));
            m_dv[i]  = rd_ok;
            if (rd_ok) begin
                m_data[i] = m_buf[i][0];
                for (int j = 0; j < 7; j++) m_buf[i][j] = m_buf[i][j+1];
                m_cnt[i]--;
            end
            if (wr_ok) begin
                m_buf[i][m_cnt[i]] = wr_data;
                m_cnt[i]++;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("u%0d_count", i), 32'(count[i]), 32'(m_cnt[i]));
            check_eq($sformatf("u%0d_empty", i), 32'(empty[i]), 32'(m_cnt[i] == 0));
            check_eq($sformatf("u%0d_full", i), 32'(full[i]), 32'(m_cnt[i] == m_depth[i]));
            check_eq($sformatf("u%0d_af", i), 32'(af_flag[i]), 32'(m_cnt[i] >= int'(af_level)));
            check_eq($sformatf("u%0d_ae", i), 32'(ae_flag[i]), 32'(m_cnt[i] <= int'(ae_level)));
            check_eq($sformatf("u%0d_ovf", i), 32'(ovf[i]), 32'(m_ovf[i]));
            check_eq($sformatf("u%0d_unf", i), 32'(unf[i]), 32'(m_unf[i]));
            if (m_fwft[i] != 0) begin
                check_eq($sformatf("u%0d_dv", i), 32'(rd_dv[i]), 32'(m_cnt[i] > 0));
                if (m_cnt[i] > 0)
                    check_eq($sformatf("u%0d_data", i), 32'(rd_data[i]), 32'(m_buf[i][0]));
            end else begin
                check_eq($sformatf("u%0d_dv", i), 32'(rd_dv[i]), 32'(m_dv[i]));
                check_eq($sformatf("u%0d_data", i), 32'(rd_data[i]), 32'(m_data[i]));
            end
        end
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, check at the next falling edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        wr_dv   = wr;
        wr_data = d;
        rd_en   = rd;
        clr_err = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    logic [4:0] ae_tab;
    logic [4:0] af_tab;

    initial begin
        rst      = 1'b1;
        wr_dv    = 1'b0;
        wr_data  = 8'h00;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        af_level = 3'd3;
        ae_level = 3'd1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        check_eq("rst_empty", 32'(empty[1]), 32'd1);

        // Standard mode single word.
        step(1'b1, 8'hAB, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("sw_dv", 32'(rd_dv[0]), 32'd1);
        check_eq("sw_data", 32'(rd_data[0]), 32'hAB);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("sw_dv_pulse", 32'(rd_dv[0]), 32'd0);
        check_eq("sw_data_hold", 32'(rd_data[0]), 32'hAB);
        check_eq("sw_count", 32'(count[0]), 32'd0);

        // Fill with thresholds AF=3 AE=1 (depth-4 view) and non-power-of-two fill (depth 5).
        ae_tab = 5'b00011;
        af_tab = 5'b11000;
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("thr_ae_%0d", k), 32'(ae_flag[0]), 32'(ae_tab[k]));
            check_eq($sformatf("thr_af_%0d", k), 32'(af_flag[0]), 32'(af_tab[k]));
            if (k < 4) step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
        end
        step(1'b1, 8'h34, 1'b0, 1'b0);
        check_eq("np2_full", 32'(full[1]), 32'd1);
        check_eq("np2_count", 32'(count[1]), 32'd5);
        step(1'b1, 8'h35, 1'b0, 1'b0);
        check_eq("np2_ovf", 32'(ovf[1]), 32'd1);
        check_eq("np2_count_hold", 32'(count[1]), 32'd5);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check_eq($sformatf("np2_rd_%0d", k), 32'(rd_data[1]), 32'(8'h30 + k));
        end
        check_eq("np2_empty", 32'(empty[1]), 32'd1);

        // FWFT presentation and pops.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        check_eq("fwft_dv", 32'(rd_dv[2]), 32'd1);
        check_eq("fwft_data", 32'(rd_data[2]), 32'h11);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("fwft_next", 32'(rd_data[2]), 32'h22);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("fwft_drained", 32'(rd_dv[2]), 32'd0);

        // Simultaneous read and write from empty, then from full.
        step(1'b1, 8'h40, 1'b1, 1'b0);
        check_eq("sim_unf", 32'(unf[1]), 32'd1);
        check_eq("sim_count1", 32'(count[1]), 32'd1);
        for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h41 + k), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 8'(8'h50 + k), 1'b1, 1'b0);
            check_eq("sim_full", 32'(full[1]), 32'd1);
            check_eq("sim_count5", 32'(count[1]), 32'd5);
            check_eq("sim_no_ovf", 32'(ovf[1]), 32'd0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("sim_clr", 32'(unf[1]), 32'd0);

        // Randomized traffic in three bias phases.
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 200; n++) begin
                int wp;
                int rp;
                wp = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
                rp = 100 - wp;
                if ($urandom_range(31, 0) == 0) begin
                    af_level = 3'($urandom_range(5, 0));
                    ae_level = 3'($urandom_range(5, 0));
                end
                step(1'($urandom_range(99, 0) < wp), 8'($urandom), 1'($urandom_range(99, 0) < rp),
                     1'($urandom_range(15, 0) == 0));
            end
        end

        // Asynchronous reset between edges during a burst, with a read pulse in flight.
        for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h70 + k), 1'b0, 1'b0);
        wr_dv   = 1'b1;
        wr_data = 8'h7F;
        rd_en   = 1'b1;
        @(posedge clk);
        model_step();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        check_eq("arst_dv_killed", 32'(rd_dv[1]), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        wr_dv   = 1'b0;
        rd_en   = 1'b0;
        check_all();
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("arst_5a", 32'(rd_data[0]), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
